pong_engine: RTL and testbench
==============================

# pong_engine

Parametrised game-state engine for the VGA Pong design. It owns ball position and velocity, both paddle positions, scores and the serve/point/game-over flow, and advances once per `frame_tick` rather than on a free-running divider. It drives coordinates into the existing `make_box` renderers and the score digits into `binaryToBCD`/`BCD_Display`. Screen size, object sizes, speeds and match length are all generic.

## Interface
- `SCREEN_W`, 640: visible width in pixels.
- `SCREEN_H`, 480: visible height in pixels.
- `PADDLE_W`, 10: paddle width in pixels.
- `PADDLE_H`, 50: paddle height in pixels.
- `BALL_SIZE`, 8: ball edge length in pixels.
- `P1_X`, 20: left paddle left edge.
- `P2_X`, 610: right paddle left edge.
- `PADDLE_STEP`, 3: paddle pixels moved per frame.
- `MAX_SPEED`, 4: maximum ball |vx|.
- `SCORE_MAX`, 9: score that ends the match (≤15).
- `POINT_FRAMES`, 60: frames the ball is frozen after a point.

Ports:
- `CLOCK_50` in 1: system clock.
- `reset` in 1: synchronous, active-high.
- `frame_tick` in 1: one-cycle pulse per frame; all game updates occur only on this pulse.
- `p1_up`, `p1_down`, `p2_up`, `p2_down` in 1 each: active-high paddle commands.
- `serve_p1`, `serve_p2` in 1 each: active-high serve/restart requests.
- `ball_x`, `ball_y` out 10: ball top-left corner.
- `p1_y`, `p2_y` out 10: paddle top edges.
- `score_p1`, `score_p2` out 4: scores.
- `game_state` out 2: `IDLE`=0, `PLAY`=1, `POINT`=2, `OVER`=3.
- `point_pulse` out 1: one-cycle pulse on entry to `POINT`.

## Operation
- **Reset values:**
  - ball at ((SCREEN_W−BALL_SIZE)/2, (SCREEN_H−BALL_SIZE)/2) = (316,236).
  - paddles at (SCREEN_H−PADDLE_H)/2 = 215.
  - scores 0, vx=vy=0, state `IDLE`, `point_pulse` 0, frame counter 0.
- **Velocity:** signed 4-bit vx and vy. Position arithmetic is done in signed 11 bits, then clamped into range before the 10-bit outputs are registered.
- **Paddles:** move in `IDLE`, `PLAY` and `POINT`; frozen in `OVER`.
  - up alone → y −= PADDLE_STEP; down alone → y += PADDLE_STEP; both or neither → hold.
  - result clamped to [0, SCREEN_H−PADDLE_H].
- **IDLE:** ball centred with v=0.
  - `serve_p1` → vx=+1, vy=−1, go to `PLAY`.
  - `serve_p2` alone → vx=−1, vy=−1, go to `PLAY`.
  - both asserted → `serve_p1` wins.
- **PLAY:** compute nx=x+vx, ny=y+vy.
  - **Top/bottom walls:**
    - ny ≤ 0 → y=0, vy=+|vy|.
    - ny ≥ SCREEN_H−BALL_SIZE → y=SCREEN_H−BALL_SIZE, vy=−|vy|.
  - **Overlap test:** a paddle overlaps the ball when y+BALL_SIZE > paddle_y and y < paddle_y+PADDLE_H, using pre-move ball y and pre-move paddle y.
  - **Left paddle hit:** vx<0, x ≥ P1_X+PADDLE_W, nx < P1_X+PADDLE_W, and left paddle overlaps. Then x=P1_X+PADDLE_W and vx=+min(|vx|+1, MAX_SPEED).
  - **Right paddle hit:** mirrored, with face P2_X−BALL_SIZE. Then vx=−min(|vx|+1, MAX_SPEED).
  - **Miss:**
    - nx ≤ 0 → score_p2 +1, go to `POINT`.
    - nx ≥ SCREEN_W−BALL_SIZE → score_p1 +1, go to `POINT`.
    - On a miss the ball is clamped to that edge.
  - Wall and paddle responses in the same frame both apply. A paddle hit takes precedence over a miss.
- **POINT:** ball frozen, v=0, counter counts frames. At POINT_FRAMES−1:
  - if the scorer's score = SCORE_MAX → `OVER`.
  - otherwise → `IDLE` with the ball recentred.
- **OVER:** holds. `serve_p1` or `serve_p2` on a tick → scores cleared, go to `IDLE`.
- **Score:** saturates at SCORE_MAX.

## Timing
- Inputs are sampled only in the cycle where `frame_tick`=1; inputs are ignored otherwise.
- All outputs are registered and updated at the clock edge ending the tick cycle, i.e. new values are visible 1 cycle after the tick.
- `point_pulse` is high for exactly the one cycle after the tick that scores.
- `reset` overrides `frame_tick` in the same cycle. Reset mid-`PLAY` or mid-`POINT` returns to reset values at the next edge.
- Back-to-back ticks on consecutive cycles are legal; each one advances one frame.

## Structure
- `pong_pkg`:
  - `game_state_t` enum.
  - `coord_t` (10-bit) and `vel_t` (signed 4-bit) typedefs.
  - `sat_inc_speed` function.
- Sub-module `pong_paddle`: one per player, handling up/down/clamp/freeze with the same parameters. Instantiated twice.
- Top-level: FSM, ball datapath, scores, frame counter.

## Test plan
- Reset, then `serve_p1` on a tick → next cycle: `PLAY`, ball (317,235).
- Ball at y=1, vy=−1 → next tick: y=0, vy=+1.
- Ball at x=31, vx=−2, overlapping p1 at y=215 → next tick: x=30, vx=+3. Repeat hits → vx saturates at 4.
- p1 moved away, ball x=1, vx=−1 → score_p2=1, `point_pulse` high 1 cycle. After 60 ticks: `IDLE`, ball (316,236).
- score_p1=8, p1 scores → after 60 ticks `OVER`. Paddles frozen. `serve_p2` tick → scores 0, `IDLE`.
- `p1_up`+`p1_down` together → no move. Holding `p1_up` from 215 → reaches 0 and stays. Reset asserted with a tick in the same cycle → reset values.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared types and helpers for the Pong game-state engine.
package pong_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLAY  = 2'd1,
        POINT = 2'd2,
        OVER  = 2'd3
    } game_state_t;

    typedef logic [9:0]        coord_t;
    typedef logic signed [3:0] vel_t;

    localparam vel_t VEL_POS1 = 4'sd1;
    localparam vel_t VEL_NEG1 = -4'sd1;

    // Magnitude of a velocity component (never called with -8).
    function automatic vel_t vel_abs(input vel_t v);
        return v[3] ? -v : v;
    endfunction

    // Speed after a paddle hit: |v|+1, capped at max_speed, returned positive.
    function automatic vel_t sat_inc_speed(input vel_t v, input int max_speed);
        int mag;
        mag = v[3] ? -int'(v) : int'(v);
        mag = mag + 1;
        if (mag > max_speed) mag = max_speed;
        return vel_t'(mag);
    endfunction

endpackage

// File: rtl/pong_paddle.sv
// One player's paddle: steps up/down on each frame tick, clamped to the
// screen, and frozen whenever the engine deasserts enable.
module pong_paddle
    import pong_pkg::*;
#(
    parameter int SCREEN_H    = 480,
    parameter int PADDLE_H    = 50,
    parameter int PADDLE_STEP = 3
) (
    input  logic   CLOCK_50,
    input  logic   reset,
    input  logic   frame_tick,
    input  logic   enable,
    input  logic   move_up,
    input  logic   move_down,
    output coord_t y
);

    localparam coord_t            Y_RESET = coord_t'((SCREEN_H - PADDLE_H) / 2);
    localparam logic signed [10:0] Y_MAX  = 11'(SCREEN_H - PADDLE_H);
    localparam logic signed [10:0] STEP   = 11'(PADDLE_STEP);

    logic signed [10:0] y_sum;
    coord_t             y_next;

    // Candidate position for this frame, computed signed so an upward step
    // past the top edge is seen as negative before clamping.
    always_comb begin
        y_sum = $signed({1'b0, y});
        if (move_up && !move_down)      y_sum = y_sum - STEP;
        else if (move_down && !move_up) y_sum = y_sum + STEP;

        if (y_sum < 11'sd0)       y_next = '0;
        else if (y_sum > Y_MAX)   y_next = coord_t'(Y_MAX);
        else                      y_next = coord_t'(y_sum);
    end

    // Paddle register: only advances on a frame tick while enabled.
    always_ff @(posedge CLOCK_50) begin
        if (reset)                      y <= Y_RESET;
        else if (frame_tick && enable)  y <= y_next;
    end

endmodule

// File: rtl/pong_engine.sv
// Pong game-state engine: ball datapath, scores, serve/point/game-over FSM
// and the post-point freeze counter. Everything advances once per frame_tick.
module pong_engine
    import pong_pkg::*;
#(
    parameter int SCREEN_W     = 640,
    parameter int SCREEN_H     = 480,
    parameter int PADDLE_W     = 10,
    parameter int PADDLE_H     = 50,
    parameter int BALL_SIZE    = 8,
    parameter int P1_X         = 20,
    parameter int P2_X         = 610,
    parameter int PADDLE_STEP  = 3,
    parameter int MAX_SPEED    = 4,
    parameter int SCORE_MAX    = 9,
    parameter int POINT_FRAMES = 60
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       p1_up,
    input  logic       p1_down,
    input  logic       p2_up,
    input  logic       p2_down,
    input  logic       serve_p1,
    input  logic       serve_p2,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic [9:0] p1_y,
    output logic [9:0] p2_y,
    output logic [3:0] score_p1,
    output logic [3:0] score_p2,
    output logic [1:0] game_state,
    output logic       point_pulse
);

    localparam coord_t             CENTER_X = coord_t'((SCREEN_W - BALL_SIZE) / 2);
    localparam coord_t             CENTER_Y = coord_t'((SCREEN_H - BALL_SIZE) / 2);
    localparam logic signed [10:0] S_ZERO   = 11'sd0;
    localparam logic signed [10:0] MAX_X    = 11'(SCREEN_W - BALL_SIZE);
    localparam logic signed [10:0] MAX_Y    = 11'(SCREEN_H - BALL_SIZE);
    localparam logic signed [10:0] P1_FACE  = 11'(P1_X + PADDLE_W);
    localparam logic signed [10:0] P2_FACE  = 11'(P2_X - BALL_SIZE);
    localparam logic [10:0]        BALL_SZ  = 11'(BALL_SIZE);
    localparam logic [10:0]        PAD_H    = 11'(PADDLE_H);
    localparam logic [3:0]         SMAX     = 4'(SCORE_MAX);
    localparam int                 CNT_W    = (POINT_FRAMES > 2) ? $clog2(POINT_FRAMES) : 1;
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(POINT_FRAMES - 1);

    game_state_t        state, state_n;
    vel_t               vx, vy, vx_n, vy_n, wall_vy;
    coord_t             bx_n, by_n;
    logic [3:0]         s1_n, s2_n;
    logic [CNT_W-1:0]   frame_cnt, cnt_n;
    logic               scorer_p1, scorer_n, pulse_n;
    logic signed [10:0] cur_x, nx, ny, wall_y;
    logic               ov1, ov2, hit1, hit2;

    // Saturating score increment.
    function automatic logic [3:0] score_inc(input logic [3:0] s);
        return (s >= SMAX) ? s : s + 4'd1;
    endfunction

    pong_paddle #(
        .SCREEN_H(SCREEN_H), .PADDLE_H(PADDLE_H), .PADDLE_STEP(PADDLE_STEP)
    ) u_paddle_p1 (
        .CLOCK_50(CLOCK_50), .reset(reset), .frame_tick(frame_tick),
        .enable(state != OVER), .move_up(p1_up), .move_down(p1_down), .y(p1_y)
    );

    pong_paddle #(
        .SCREEN_H(SCREEN_H), .PADDLE_H(PADDLE_H), .PADDLE_STEP(PADDLE_STEP)
    ) u_paddle_p2 (
        .CLOCK_50(CLOCK_50), .reset(reset), .frame_tick(frame_tick),
        .enable(state != OVER), .move_up(p2_up), .move_down(p2_down), .y(p2_y)
    );

    assign game_state = state;

    // Next-frame state: serve, ball motion with wall/paddle/miss handling,
    // post-point countdown and match restart.
    always_comb begin
        // NOTE: every target gets a default before any branch; a path that
        // leaves one unassigned would infer a latch.
        state_n  = state;
        bx_n     = ball_x;
        by_n     = ball_y;
        vx_n     = vx;
        vy_n     = vy;
        s1_n     = score_p1;
        s2_n     = score_p2;
        cnt_n    = frame_cnt;
        scorer_n = scorer_p1;
        pulse_n  = 1'b0;

        cur_x = $signed({1'b0, ball_x});
        nx    = cur_x + $signed({{7{vx[3]}}, vx});
        ny    = $signed({1'b0, ball_y}) + $signed({{7{vy[3]}}, vy});

        // Overlap uses pre-move ball and paddle positions.
        ov1 = (({1'b0, ball_y} + BALL_SZ) > {1'b0, p1_y}) && ({1'b0, ball_y} < ({1'b0, p1_y} + PAD_H));
        ov2 = (({1'b0, ball_y} + BALL_SZ) > {1'b0, p2_y}) && ({1'b0, ball_y} < ({1'b0, p2_y} + PAD_H));
        hit1 = vx[3] && (cur_x >= P1_FACE) && (nx < P1_FACE) && ov1;
        hit2 = !vx[3] && (vx != '0) && (cur_x <= P2_FACE) && (nx > P2_FACE) && ov2;

        if (ny <= S_ZERO) begin
            wall_y  = S_ZERO;
            wall_vy = vel_abs(vy);
        end else if (ny >= MAX_Y) begin
            wall_y  = MAX_Y;
            wall_vy = -vel_abs(vy);
        end else begin
            wall_y  = ny;
            wall_vy = vy;
        end

        if (frame_tick) begin
            case (state)
                IDLE: begin
                    if (serve_p1) begin
                        vx_n    = VEL_POS1;
                        vy_n    = VEL_NEG1;
                        bx_n    = CENTER_X + 10'd1;
                        by_n    = CENTER_Y - 10'd1;
                        state_n = PLAY;
                    end else if (serve_p2) begin
                        vx_n    = VEL_NEG1;
                        vy_n    = VEL_NEG1;
                        bx_n    = CENTER_X - 10'd1;
                        by_n    = CENTER_Y - 10'd1;
                        state_n = PLAY;
                    end
                end

                PLAY: begin
                    by_n = coord_t'(wall_y);
                    vy_n = wall_vy;
                    if (hit1) begin
                        bx_n = coord_t'(P1_FACE);
                        vx_n = sat_inc_speed(vx, MAX_SPEED);
                    end else if (hit2) begin
                        bx_n = coord_t'(P2_FACE);
                        vx_n = -sat_inc_speed(vx, MAX_SPEED);
                    end else if (nx <= S_ZERO) begin
                        bx_n     = '0;
                        s2_n     = score_inc(score_p2);
                        scorer_n = 1'b0;
                        vx_n     = '0;
                        vy_n     = '0;
                        cnt_n    = '0;
                        pulse_n  = 1'b1;
                        state_n  = POINT;
                    end else if (nx >= MAX_X) begin
                        bx_n     = coord_t'(MAX_X);
                        s1_n     = score_inc(score_p1);
                        scorer_n = 1'b1;
                        vx_n     = '0;
                        vy_n     = '0;
                        cnt_n    = '0;
                        pulse_n  = 1'b1;
                        state_n  = POINT;
                    end else begin
                        bx_n = coord_t'(nx);
                    end
                end

                POINT: begin
                    if (frame_cnt == CNT_LAST) begin
                        cnt_n = '0;
                        if ((scorer_p1 ? score_p1 : score_p2) == SMAX) begin
                            state_n = OVER;
                        end else begin
                            bx_n    = CENTER_X;
                            by_n    = CENTER_Y;
                            state_n = IDLE;
                        end
                    end else begin
                        cnt_n = frame_cnt + CNT_W'(1);
                    end
                end

                OVER: begin
                    if (serve_p1 || serve_p2) begin
                        s1_n    = '0;
                        s2_n    = '0;
                        bx_n    = CENTER_X;
                        by_n    = CENTER_Y;
                        vx_n    = '0;
                        vy_n    = '0;
                        state_n = IDLE;
                    end
                end
            endcase
        end
    end

    // Game-state registers with synchronous reset to the centred serve position.
    always_ff @(posedge CLOCK_50) begin
        // NOTE: non-blocking assignments so every register samples the
        // pre-edge values regardless of statement order.
        if (reset) begin
            state       <= IDLE;
            ball_x      <= CENTER_X;
            ball_y      <= CENTER_Y;
            vx          <= '0;
            vy          <= '0;
            score_p1    <= '0;
            score_p2    <= '0;
            frame_cnt   <= '0;
            scorer_p1   <= 1'b0;
            point_pulse <= 1'b0;
        end else begin
            state       <= state_n;
            ball_x      <= bx_n;
            ball_y      <= by_n;
            vx          <= vx_n;
            vy          <= vy_n;
            score_p1    <= s1_n;
            score_p2    <= s2_n;
            frame_cnt   <= cnt_n;
            scorer_p1   <= scorer_n;
            point_pulse <= pulse_n;
        end
    end

endmodule

// File: tb/tb_pong_engine.sv
// Directed testbench for pong_engine with hand-traced ball trajectories.
module tb_pong_engine;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PLAY  = 2'd1;
    localparam logic [1:0] ST_POINT = 2'd2;
    localparam logic [1:0] ST_OVER  = 2'd3;

    // Paddle command sets {p1_up, p1_down, p2_up, p2_down}.
    localparam logic [3:0] NONE = 4'b0000;
    localparam logic [3:0] P1U  = 4'b1000;
    localparam logic [3:0] P1D  = 4'b0100;
    localparam logic [3:0] P2U  = 4'b0010;
    localparam logic [3:0] P2D  = 4'b0001;
    // Serve sets {serve_p1, serve_p2}.
    localparam logic [1:0] NOSRV = 2'b00;
    localparam logic [1:0] SRV1  = 2'b10;
    localparam logic [1:0] SRV2  = 2'b01;

    logic       CLOCK_50 = 1'b0;
    logic       reset = 1'b0, frame_tick = 1'b0;
    logic       p1_up = 1'b0, p1_down = 1'b0, p2_up = 1'b0, p2_down = 1'b0;
    logic       serve_p1 = 1'b0, serve_p2 = 1'b0;
    logic [9:0] ball_x, ball_y, p1_y, p2_y;
    logic [3:0] score_p1, score_p2;
    logic [1:0] game_state;
    logic       point_pulse;

    int n_cmp = 0;
    int n_bad = 0;

    pong_engine dut (
        .CLOCK_50(CLOCK_50), .reset(reset), .frame_tick(frame_tick),
        .p1_up(p1_up), .p1_down(p1_down), .p2_up(p2_up), .p2_down(p2_down),
        .serve_p1(serve_p1), .serve_p2(serve_p2),
        .ball_x(ball_x), .ball_y(ball_y), .p1_y(p1_y), .p2_y(p2_y),
        .score_p1(score_p1), .score_p2(score_p2),
        .game_state(game_state), .point_pulse(point_pulse)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    // n consecutive tick cycles with the given commands; outputs are then
    // sampled on the negedge after the last tick edge.
    task automatic tick_n(input int n, input logic [3:0] pad, input logic [1:0] srv);
        @(negedge CLOCK_50);
        frame_tick = 1'b1;
        {p1_up, p1_down, p2_up, p2_down} = pad;
        {serve_p1, serve_p2} = srv;
        repeat (n) @(negedge CLOCK_50);
        frame_tick = 1'b0;
        {p1_up, p1_down, p2_up, p2_down} = NONE;
        {serve_p1, serve_p2} = NOSRV;
    endtask

    task automatic do_reset();
        @(negedge CLOCK_50);
        reset = 1'b1;
        @(negedge CLOCK_50);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if ({ball_x, ball_y} !== {10'd316, 10'd236}) begin n_bad++;
            $display("FAIL reset_ball: got (%0d,%0d) expected (316,236)", ball_x, ball_y); end
        n_cmp++; if ({p1_y, p2_y} !== {10'd215, 10'd215}) begin n_bad++;
            $display("FAIL reset_paddles: got (%0d,%0d) expected (215,215)", p1_y, p2_y); end
        n_cmp++; if ({score_p1, score_p2} !== 8'h00) begin n_bad++;
            $display("FAIL reset_scores: got (%0d,%0d) expected (0,0)", score_p1, score_p2); end
        n_cmp++; if ({game_state, point_pulse} !== {ST_IDLE, 1'b0}) begin n_bad++;
            $display("FAIL reset_state: got state %0d pulse %0d expected 0 0", game_state, point_pulse); end
    endtask

    task automatic test_serve();
        do_reset();
        // Inputs without a tick are ignored.
        @(negedge CLOCK_50);
        serve_p1 = 1'b1; p1_up = 1'b1;
        repeat (4) @(negedge CLOCK_50);
        serve_p1 = 1'b0; p1_up = 1'b0;
        n_cmp++; if ({game_state, p1_y} !== {ST_IDLE, 10'd215}) begin n_bad++;
            $display("FAIL no_tick_ignored: got state %0d p1_y %0d expected 0 215", game_state, p1_y); end
        // Both serves: p1 wins.
        tick_n(1, NONE, SRV1 | SRV2);
        n_cmp++; if ({game_state, ball_x, ball_y} !== {ST_PLAY, 10'd317, 10'd235}) begin n_bad++;
            $display("FAIL serve_both: got state %0d (%0d,%0d) expected 1 (317,235)", game_state, ball_x, ball_y); end
        do_reset();
        tick_n(1, NONE, SRV2);
        n_cmp++; if ({game_state, ball_x, ball_y} !== {ST_PLAY, 10'd315, 10'd235}) begin n_bad++;
            $display("FAIL serve_p2: got state %0d (%0d,%0d) expected 1 (315,235)", game_state, ball_x, ball_y); end
    endtask

    // One long rally: top wall, right hit, left hit, bottom wall, speed-up to 4.
    task automatic test_wall_and_hits();
        do_reset();
        tick_n(1, P2U, SRV1);                                   // t=1
        n_cmp++; if ({game_state, ball_x, ball_y} !== {ST_PLAY, 10'd317, 10'd235}) begin n_bad++;
            $display("FAIL serve_p1: got state %0d (%0d,%0d) expected 1 (317,235)", game_state, ball_x, ball_y); end
        tick_n(52, P2U, NOSRV);                                 // t=53
        n_cmp++; if (p2_y !== 10'd56) begin n_bad++;
            $display("FAIL p2_up_steps: got %0d expected 56", p2_y); end
        tick_n(182, NONE, NOSRV);                               // t=235
        n_cmp++; if ({ball_x, ball_y} !== {10'd551, 10'd1}) begin n_bad++;
            $display("FAIL near_top: got (%0d,%0d) expected (551,1)", ball_x, ball_y); end
        tick_n(1, NONE, NOSRV);                                 // t=236
        n_cmp++; if ({ball_x, ball_y} !== {10'd552, 10'd0}) begin n_bad++;
            $display("FAIL top_wall: got (%0d,%0d) expected (552,0)", ball_x, ball_y); end
        tick_n(1, NONE, NOSRV);                                 // t=237
        n_cmp++; if ({ball_x, ball_y} !== {10'd553, 10'd1}) begin n_bad++;
            $display("FAIL top_bounce: got (%0d,%0d) expected (553,1)", ball_x, ball_y); end
        tick_n(49, NONE, NOSRV);                                // t=286
        tick_n(1, NONE, NOSRV);                                 // t=287 right hit
        n_cmp++; if ({ball_x, ball_y} !== {10'd602, 10'd51}) begin n_bad++;
            $display("FAIL right_hit: got (%0d,%0d) expected (602,51)", ball_x, ball_y); end
        tick_n(1, NONE, NOSRV);                                 // t=288
        n_cmp++; if ({ball_x, ball_y} !== {10'd600, 10'd52}) begin n_bad++;
            $display("FAIL right_hit_vx: got (%0d,%0d) expected (600,52)", ball_x, ball_y); end
        tick_n(40, P1D, NOSRV);                                 // t=328
        tick_n(120, P2D, NOSRV);                                // t=448
        n_cmp++; if ({p1_y, p2_y} !== {10'd335, 10'd416}) begin n_bad++;
            $display("FAIL paddles_moved: got (%0d,%0d) expected (335,416)", p1_y, p2_y); end
        tick_n(125, NONE, NOSRV);                               // t=573
        n_cmp++; if ({ball_x, ball_y} !== {10'd30, 10'd337}) begin n_bad++;
            $display("FAIL at_left_face: got (%0d,%0d) expected (30,337)", ball_x, ball_y); end
        tick_n(1, NONE, NOSRV);                                 // t=574 left hit
        tick_n(1, NONE, NOSRV);                                 // t=575
        n_cmp++; if ({ball_x, ball_y} !== {10'd33, 10'd339}) begin n_bad++;
            $display("FAIL left_hit_vx3: got (%0d,%0d) expected (33,339)", ball_x, ball_y); end
        tick_n(133, NONE, NOSRV);                               // t=708
        n_cmp++; if ({ball_x, ball_y} !== {10'd432, 10'd472}) begin n_bad++;
            $display("FAIL bottom_wall: got (%0d,%0d) expected (432,472)", ball_x, ball_y); end
        tick_n(1, NONE, NOSRV);                                 // t=709
        n_cmp++; if ({ball_x, ball_y} !== {10'd435, 10'd471}) begin n_bad++;
            $display("FAIL bottom_bounce: got (%0d,%0d) expected (435,471)", ball_x, ball_y); end
        tick_n(20, P1U, NOSRV);                                 // t=729
        tick_n(35, NONE, NOSRV);                                // t=764
        tick_n(1, NONE, NOSRV);                                 // t=765 right hit
        tick_n(1, NONE, NOSRV);                                 // t=766
        n_cmp++; if ({ball_x, ball_y} !== {10'd598, 10'd414}) begin n_bad++;
            $display("FAIL right_hit_vx4: got (%0d,%0d) expected (598,414)", ball_x, ball_y); end
        tick_n(142, NONE, NOSRV);                               // t=908
        tick_n(1, NONE, NOSRV);                                 // t=909 left hit
        n_cmp++; if ({ball_x, ball_y} !== {10'd30, 10'd271}) begin n_bad++;
            $display("FAIL left_hit2: got (%0d,%0d) expected (30,271)", ball_x, ball_y); end
        tick_n(1, NONE, NOSRV);                                 // t=910
        n_cmp++; if ({ball_x, ball_y, game_state} !== {10'd34, 10'd270, ST_PLAY}) begin n_bad++;
            $display("FAIL speed_saturated: got (%0d,%0d) state %0d expected (34,270) 1", ball_x, ball_y, game_state); end
    endtask

    task automatic test_paddles();
        do_reset();
        tick_n(1, P1U | P1D, NOSRV);
        n_cmp++; if (p1_y !== 10'd215) begin n_bad++;
            $display("FAIL paddle_both_hold: got %0d expected 215", p1_y); end
        tick_n(80, P1U, NOSRV);
        n_cmp++; if (p1_y !== 10'd0) begin n_bad++;
            $display("FAIL paddle_top_clamp: got %0d expected 0", p1_y); end
        tick_n(150, P1D, NOSRV);
        n_cmp++; if ({p1_y, p2_y} !== {10'd430, 10'd215}) begin n_bad++;
            $display("FAIL paddle_bottom_clamp: got (%0d,%0d) expected (430,215)", p1_y, p2_y); end
    endtask

    task automatic test_score_p2();
        do_reset();
        tick_n(1, NONE, SRV2);
        tick_n(315, NONE, NOSRV);                               // t=316 miss left
        n_cmp++; if ({ball_x, ball_y} !== {10'd0, 10'd80}) begin n_bad++;
            $display("FAIL miss_left_ball: got (%0d,%0d) expected (0,80)", ball_x, ball_y); end
        n_cmp++; if ({score_p1, score_p2, game_state, point_pulse} !== {4'd0, 4'd1, ST_POINT, 1'b1}) begin n_bad++;
            $display("FAIL miss_left_score: got s1 %0d s2 %0d state %0d pulse %0d expected 0 1 2 1",
                     score_p1, score_p2, game_state, point_pulse); end
        @(negedge CLOCK_50);
        n_cmp++; if (point_pulse !== 1'b0) begin n_bad++;
            $display("FAIL pulse_one_cycle: got %0d expected 0", point_pulse); end
        tick_n(59, NONE, NOSRV);
        n_cmp++; if ({game_state, ball_x, ball_y} !== {ST_POINT, 10'd0, 10'd80}) begin n_bad++;
            $display("FAIL point_frozen: got state %0d (%0d,%0d) expected 2 (0,80)", game_state, ball_x, ball_y); end
        tick_n(1, NONE, NOSRV);
        n_cmp++; if ({game_state, ball_x, ball_y} !== {ST_IDLE, 10'd316, 10'd236}) begin n_bad++;
            $display("FAIL point_to_idle: got state %0d (%0d,%0d) expected 0 (316,236)", game_state, ball_x, ball_y); end
    endtask

    task automatic test_match_over();
        do_reset();
        for (int i = 1; i <= 9; i++) begin
            tick_n(1, NONE, SRV1);
            tick_n(315, NONE, NOSRV);                           // t=316 miss right
            n_cmp++; if ({score_p1, game_state, ball_x, ball_y} !== {4'(i), ST_POINT, 10'd632, 10'd80}) begin n_bad++;
                $display("FAIL match_point%0d: got s1 %0d state %0d (%0d,%0d) expected %0d 2 (632,80)",
                         i, score_p1, game_state, ball_x, ball_y, i); end
            tick_n(60, NONE, NOSRV);
            n_cmp++; if (game_state !== ((i == 9) ? ST_OVER : ST_IDLE)) begin n_bad++;
                $display("FAIL match_after%0d: got state %0d expected %0d", i, game_state, (i == 9) ? 3 : 0); end
        end
        tick_n(3, P1U | P2D, NOSRV);
        n_cmp++; if ({p1_y, p2_y, game_state} !== {10'd215, 10'd215, ST_OVER}) begin n_bad++;
            $display("FAIL over_frozen: got (%0d,%0d) state %0d expected (215,215) 3", p1_y, p2_y, game_state); end
        tick_n(1, NONE, SRV2);
        n_cmp++; if ({score_p1, score_p2, game_state, ball_x, ball_y} !== {4'd0, 4'd0, ST_IDLE, 10'd316, 10'd236}) begin n_bad++;
            $display("FAIL over_restart: got s %0d/%0d state %0d (%0d,%0d) expected 0/0 0 (316,236)",
                     score_p1, score_p2, game_state, ball_x, ball_y); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        tick_n(1, NONE, SRV1);
        tick_n(10, P1D, NOSRV);
        @(negedge CLOCK_50);
        reset = 1'b1; frame_tick = 1'b1; p1_up = 1'b1; serve_p1 = 1'b1;
        @(negedge CLOCK_50);
        reset = 1'b0; frame_tick = 1'b0; p1_up = 1'b0; serve_p1 = 1'b0;
        n_cmp++; if ({game_state, ball_x, ball_y, p1_y} !== {ST_IDLE, 10'd316, 10'd236, 10'd215}) begin n_bad++;
            $display("FAIL reset_with_tick: got state %0d (%0d,%0d) p1 %0d expected 0 (316,236) 215",
                     game_state, ball_x, ball_y, p1_y); end
    endtask

    initial begin
        test_reset();
        test_serve();
        test_wall_and_hits();
        test_paddles();
        test_score_p2();
        test_match_over();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #20ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
